// File: rtl/mouse_cmd_arbiter.sv
// mouse_cmd_arbiter: shares one PS/2 mouse transmitter/receiver pair between
// two command requesters.
//   Port 0: the mouse init/stream state machine.
//   Port 1: the processor bus config path.
//
// Each transaction sends a command byte and waits for its ACK. It then
// optionally sends one argument byte and waits for that ACK too.
// A resend, a receiver error or a timeout retries only the current byte, up to
// MAX_RETRIES times. The owner then receives DONE, or DONE together with ERR.
//
// Optional feature, macro MOUSE_ARB_ROUND_ROBIN_EN:
//   Defined:   round-robin arbitration using a last-grant flag.
//   Undefined: fixed priority, and port 0 wins ties.
module mouse_cmd_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter logic [7:0]  ACK_BYTE       = 8'hFA,
  parameter logic [7:0]  RESEND_BYTE    = 8'hFE
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       REQ0,
  input  logic       REQ1,
  input  logic [7:0] CMD0,
  input  logic [7:0] CMD1,
  input  logic [7:0] ARG0,
  input  logic [7:0] ARG1,
  input  logic       HAS_ARG0,
  input  logic       HAS_ARG1,
  output logic       GNT0,
  output logic       GNT1,
  output logic       DONE0,
  output logic       DONE1,
  output logic       ERR0,
  output logic       ERR1,
  output logic       SEND_BYTE,
  output logic [7:0] BYTE_TO_SEND,
  input  logic       BYTE_SENT,
  output logic       READ_ENABLE,
  input  logic       BYTE_READY,
  input  logic [7:0] BYTE_READ,
  input  logic [1:0] BYTE_ERROR_CODE,
  output logic       BUSY,
  output logic [7:0] LAST_RESP
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SEND_CMD,
    S_WAIT_CMD_SENT,
    S_WAIT_CMD_ACK,
    S_SEND_ARG,
    S_WAIT_ARG_SENT,
    S_WAIT_ARG_ACK,
    S_DONE,
    S_FAIL
  } state_e;

  state_e          state_q, state_d;
  logic            owner_q, owner_d;      // 0: port 0 owns the grant, 1: port 1
  logic [7:0]      cmd_q, cmd_d;
  logic [7:0]      arg_q, arg_d;
  logic            has_arg_q, has_arg_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic            send_byte_q, send_byte_d;
  logic [7:0]      byte_to_send_q, byte_to_send_d;
  logic [7:0]      last_resp_q, last_resp_d;
`ifdef MOUSE_ARB_ROUND_ROBIN_EN
  logic            last_gnt_q, last_gnt_d;
`endif

  logic            pick;
  logic            take_retry;
  state_e          retry_state;
  logic            timed_out;
  logic            resp_retry;

  // Flag the last allowed cycle of any wait state.
  assign timed_out = (timer_q == TW'(TIMEOUT_CYCLES - 1));

  // An explicit resend, any unexpected byte, or a receiver error all retry
  // the current byte.
  assign resp_retry = (BYTE_READ == RESEND_BYTE) || (BYTE_READ != ACK_BYTE) ||
                      (BYTE_ERROR_CODE != 2'b00);

  // Next-state logic: arbitration, byte sequencing, retries and timeouts.
  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves one unassigned, which would infer a latch.
    state_d        = state_q;
    owner_d        = owner_q;
    cmd_d          = cmd_q;
    arg_d          = arg_q;
    has_arg_d      = has_arg_q;
    timer_d        = timer_q;
    retry_d        = retry_q;
    send_byte_d    = 1'b0;
    byte_to_send_d = byte_to_send_q;
    last_resp_d    = last_resp_q;
    pick           = 1'b0;
    take_retry     = 1'b0;
    retry_state    = S_SEND_CMD;
`ifdef MOUSE_ARB_ROUND_ROBIN_EN
    last_gnt_d     = last_gnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (REQ0 || REQ1) begin
`ifdef MOUSE_ARB_ROUND_ROBIN_EN
          pick       = (REQ0 && REQ1) ? ~last_gnt_q : REQ1;
          last_gnt_d = pick;
`else
          pick       = ~REQ0;
`endif
          owner_d   = pick;
          cmd_d     = pick ? CMD1 : CMD0;
          arg_d     = pick ? ARG1 : ARG0;
          has_arg_d = pick ? HAS_ARG1 : HAS_ARG0;
          retry_d   = '0;
          state_d   = S_SEND_CMD;
        end
      end

      S_SEND_CMD: begin
        send_byte_d    = 1'b1;
        byte_to_send_d = cmd_q;
        timer_d        = '0;
        state_d        = S_WAIT_CMD_SENT;
      end

      S_WAIT_CMD_SENT: begin
        if (BYTE_SENT) begin
          timer_d = '0;
          state_d = S_WAIT_CMD_ACK;
        end else if (timed_out) begin
          take_retry  = 1'b1;
          retry_state = S_SEND_CMD;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      S_WAIT_CMD_ACK: begin
        if (BYTE_READY) begin
          last_resp_d = BYTE_READ;
          if (!resp_retry) begin
            retry_d = '0;
            state_d = has_arg_q ? S_SEND_ARG : S_DONE;
          end else begin
            take_retry  = 1'b1;
            retry_state = S_SEND_CMD;
          end
        end else if (timed_out) begin
          take_retry  = 1'b1;
          retry_state = S_SEND_CMD;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      S_SEND_ARG: begin
        send_byte_d    = 1'b1;
        byte_to_send_d = arg_q;
        timer_d        = '0;
        state_d        = S_WAIT_ARG_SENT;
      end

      S_WAIT_ARG_SENT: begin
        if (BYTE_SENT) begin
          timer_d = '0;
          state_d = S_WAIT_ARG_ACK;
        end else if (timed_out) begin
          take_retry  = 1'b1;
          retry_state = S_SEND_ARG;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      S_WAIT_ARG_ACK: begin
        if (BYTE_READY) begin
          last_resp_d = BYTE_READ;
          if (!resp_retry) begin
            retry_d = '0;
            state_d = S_DONE;
          end else begin
            take_retry  = 1'b1;
            retry_state = S_SEND_ARG;
          end
        end else if (timed_out) begin
          take_retry  = 1'b1;
          retry_state = S_SEND_ARG;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      S_DONE:  state_d = S_IDLE;
      S_FAIL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A retry re-sends only the byte that failed; the budget is per byte.
    if (take_retry) begin
      if (retry_q < RW'(MAX_RETRIES)) begin
        retry_d = retry_q + RW'(1);
        state_d = retry_state;
      end else begin
        state_d = S_FAIL;
      end
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      // NOTE: the latched command registers are reset with the rest. They are
      // few, and resetting them keeps every output at a defined 0.
      state_q        <= S_IDLE;
      owner_q        <= 1'b0;
      cmd_q          <= '0;
      arg_q          <= '0;
      has_arg_q      <= 1'b0;
      timer_q        <= '0;
      retry_q        <= '0;
      send_byte_q    <= 1'b0;
      byte_to_send_q <= '0;
      last_resp_q    <= '0;
`ifdef MOUSE_ARB_ROUND_ROBIN_EN
      last_gnt_q     <= 1'b1;
`endif
    end else begin
      // NOTE: non-blocking assignments make all flops update together from
      // the values they held before this clock edge.
      state_q        <= state_d;
      owner_q        <= owner_d;
      cmd_q          <= cmd_d;
      arg_q          <= arg_d;
      has_arg_q      <= has_arg_d;
      timer_q        <= timer_d;
      retry_q        <= retry_d;
      send_byte_q    <= send_byte_d;
      byte_to_send_q <= byte_to_send_d;
      last_resp_q    <= last_resp_d;
`ifdef MOUSE_ARB_ROUND_ROBIN_EN
      last_gnt_q     <= last_gnt_d;
`endif
    end
  end

  assign BUSY         = (state_q != S_IDLE);
  assign GNT0         = BUSY & ~owner_q;
  assign GNT1         = BUSY &  owner_q;
  assign DONE0        = ((state_q == S_DONE) || (state_q == S_FAIL)) & ~owner_q;
  assign DONE1        = ((state_q == S_DONE) || (state_q == S_FAIL)) &  owner_q;
  assign ERR0         = (state_q == S_FAIL) & ~owner_q;
  assign ERR1         = (state_q == S_FAIL) &  owner_q;
  assign READ_ENABLE  = (state_q == S_WAIT_CMD_ACK) || (state_q == S_WAIT_ARG_ACK);
  assign SEND_BYTE    = send_byte_q;
  assign BYTE_TO_SEND = byte_to_send_q;
  assign LAST_RESP    = last_resp_q;

endmodule

// File: tb/tb_mouse_cmd_arbiter.sv
// Self-checking bench for mouse_cmd_arbiter.
//
// A device model answers each transmitted byte from a response queue.
// A transaction-level reference model predicts, from the response script,
// which bytes go out, the final outcome and LAST_RESP.
// A monitor compares each DONE against the predicted entry.
module tb_mouse_cmd_arbiter;

  localparam int unsigned TO  = 40;
  localparam int unsigned MR  = 3;
  localparam logic [7:0]  ACK = 8'hFA;
  localparam logic [7:0]  NAK = 8'hFE;

  typedef struct packed {
    logic       silent;
    logic [1:0] e;
    logic [7:0] b;
  } resp_t;

  logic       CLK, RESET, REQ0, REQ1;
  logic [7:0] CMD0, CMD1, ARG0, ARG1;
  logic       HAS_ARG0, HAS_ARG1;
  logic       GNT0, GNT1, DONE0, DONE1, ERR0, ERR1;
  logic       SEND_BYTE, BYTE_SENT, READ_ENABLE, BYTE_READY, BUSY;
  logic [7:0] BYTE_TO_SEND, BYTE_READ, LAST_RESP;
  logic [1:0] BYTE_ERROR_CODE;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int ready_cyc = 0;

  resp_t      dev_q[$];
  resp_t      script_q[$];
  logic [7:0] sent_log[$];
  int         send_cyc_q[$];
  bit         exp_port_q[$];
  bit         exp_err_q[$];
  logic [7:0] exp_lr_q[$];
  int         exp_n_q[$];
  logic [7:0] exp_bytes_q[$];
  logic [7:0] model_last;
  bit         model_rr_last;

  mouse_cmd_arbiter #(.TIMEOUT_CYCLES(TO), .MAX_RETRIES(MR)) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ0(REQ0), .REQ1(REQ1),
    .CMD0(CMD0), .CMD1(CMD1),
    .ARG0(ARG0), .ARG1(ARG1),
    .HAS_ARG0(HAS_ARG0), .HAS_ARG1(HAS_ARG1),
    .GNT0(GNT0), .GNT1(GNT1),
    .DONE0(DONE0), .DONE1(DONE1),
    .ERR0(ERR0), .ERR1(ERR1),
    .SEND_BYTE(SEND_BYTE), .BYTE_TO_SEND(BYTE_TO_SEND), .BYTE_SENT(BYTE_SENT),
    .READ_ENABLE(READ_ENABLE), .BYTE_READY(BYTE_READY), .BYTE_READ(BYTE_READ),
    .BYTE_ERROR_CODE(BYTE_ERROR_CODE),
    .BUSY(BUSY), .LAST_RESP(LAST_RESP)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic resp_t mk(input logic s, input logic [1:0] e, input logic [7:0] b);
    resp_t r;
    r.silent = s;
    r.e      = e;
    r.b      = b;
    return r;
  endfunction

  function automatic logic [31:0] outs();
    return {7'b0, GNT0, GNT1, DONE0, DONE1, ERR0, ERR1, SEND_BYTE, READ_ENABLE,
            BUSY, BYTE_TO_SEND, LAST_RESP};
  endfunction

  // Scripted response first; otherwise ACK (mode 0) or a random mix (mode 1).
  function automatic resp_t next_resp(input int mode);
    int k;
    if (script_q.size() > 0) return script_q.pop_front();
    if (mode == 0) return mk(1'b0, 2'b00, ACK);
    k = int'($urandom_range(0, 99));
    if (k < 60) return mk(1'b0, 2'b00, ACK);
    if (k < 75) return mk(1'b0, 2'b00, NAK);
    if (k < 85) return mk(1'b0, 2'($urandom_range(1, 3)), ACK);
    if (k < 95) return mk(1'b0, 2'b00, 8'($urandom));
    return mk(1'b1, 2'b00, 8'h00);
  endfunction

  // Reference model for one transaction.
  // Walks the bytes to send and picks a response for each transmission. An
  // ACK with no error advances to the next byte; anything else uses one retry.
  task automatic plan_txn(input bit p, input logic [7:0] c, input logic [7:0] a,
                          input bit h, input int mode);
    int idx = 0;
    int tries = 0;
    int n = 0;
    bit err = 0;
    resp_t r;
    while (idx < (h ? 2 : 1) && !err) begin
      exp_bytes_q.push_back(idx == 0 ? c : a);
      n++;
      r = next_resp(mode);
      dev_q.push_back(r);
      if (!r.silent) model_last = r.b;
      if (!r.silent && r.b == ACK && r.e == 2'b00) begin
        idx++;
        tries = 0;
      end else if (tries < MR) begin
        tries++;
      end else begin
        err = 1;
      end
    end
    exp_port_q.push_back(p);
    exp_err_q.push_back(err);
    exp_lr_q.push_back(model_last);
    exp_n_q.push_back(n);
    model_rr_last = p;
  endtask

  function automatic bit winner();
`ifdef MOUSE_ARB_ROUND_ROBIN_EN
    return !model_rr_last;
`else
    return 1'b0;
`endif
  endfunction

  task automatic set_port(input bit p, input logic [7:0] c, input logic [7:0] a, input bit h);
    if (p) begin CMD1 = c; ARG1 = a; HAS_ARG1 = h; end
    else   begin CMD0 = c; ARG0 = a; HAS_ARG0 = h; end
  endtask

  task automatic set_req(input bit p, input logic v);
    if (p) REQ1 = v; else REQ0 = v;
  endtask

  task automatic clear_model();
    dev_q.delete(); script_q.delete(); sent_log.delete(); send_cyc_q.delete();
    exp_port_q.delete(); exp_err_q.delete(); exp_lr_q.delete();
    exp_n_q.delete(); exp_bytes_q.delete();
    model_last    = 8'h00;
    model_rr_last = 1'b1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    REQ0  = 1'b0;
    REQ1  = 1'b0;
    repeat (2) @(negedge CLK);
    clear_model();
    RESET = 1'b0;
  endtask

  // Waits (bounded) for DONE on port p and returns on that negedge.
  task automatic wait_done(input bit p);
    int n = 0;
    bit got = 0;
    while (n < 3000 && !got) begin
      @(negedge CLK);
      n++;
      if (p ? DONE1 : DONE0) got = 1;
    end
    check("done_seen", {31'b0, got}, 32'd1);
    if (!got) do_reset();
  endtask

  // Device model: acknowledges transmission, then answers from dev_q.
  resp_t      dev_r;
  logic [7:0] dev_sb;
  initial begin
    BYTE_SENT = 1'b0; BYTE_READY = 1'b0; BYTE_READ = 8'h00; BYTE_ERROR_CODE = 2'b00;
    forever begin
      @(negedge CLK);
      if (SEND_BYTE && !RESET) begin
        dev_sb = BYTE_TO_SEND;
        sent_log.push_back(dev_sb);
        send_cyc_q.push_back(cyc);
        repeat ($urandom_range(1, 3)) @(negedge CLK);
        check("byte_stable", {24'b0, BYTE_TO_SEND}, {24'b0, dev_sb});
        BYTE_SENT = 1'b1;
        @(negedge CLK);
        BYTE_SENT = 1'b0;
        dev_r = (dev_q.size() > 0) ? dev_q.pop_front() : mk(1'b0, 2'b00, ACK);
        if (!dev_r.silent) begin
          repeat ($urandom_range(0, 3)) @(negedge CLK);
          BYTE_READY      = 1'b1;
          BYTE_READ       = dev_r.b;
          BYTE_ERROR_CODE = dev_r.e;
          ready_cyc       = cyc;
          @(negedge CLK);
          BYTE_READY      = 1'b0;
          BYTE_ERROR_CODE = 2'b00;
        end
      end
    end
  end

  // Monitor: pops one prediction per DONE and compares.
  initial begin
    bit         mp, me;
    int         mn;
    logic [7:0] eb;
    forever begin
      @(negedge CLK);
      if ((DONE0 || DONE1) && !RESET) begin
        if (exp_port_q.size() == 0) begin
          check("unexpected_done", {30'b0, DONE1, DONE0}, 32'd0);
        end else begin
          mp = exp_port_q.pop_front();
          me = exp_err_q.pop_front();
          mn = exp_n_q.pop_front();
          check("done_port", {30'b0, DONE1, DONE0}, mp ? 32'd2 : 32'd1);
          check("err_flags", {30'b0, ERR1, ERR0}, me ? (mp ? 32'd2 : 32'd1) : 32'd0);
          check("gnt_at_done", {31'b0, mp ? GNT1 : GNT0}, 32'd1);
          check("last_resp", {24'b0, LAST_RESP}, {24'b0, exp_lr_q.pop_front()});
          check("sent_count", sent_log.size(), mn);
          for (int i = 0; i < mn; i++) begin
            eb = exp_bytes_q.pop_front();
            if (i < sent_log.size()) check("sent_byte", {24'b0, sent_log[i]}, {24'b0, eb});
          end
          if (!me) check("ack_to_done", cyc - ready_cyc, 32'd1);
        end
        sent_log.delete();
        @(negedge CLK);
        check("drop_after_done", {29'b0, BUSY, GNT0, GNT1}, 32'd0);
      end
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         w, p, h;
    logic [7:0] c, a;
    int         seen;
    RESET = 1'b1;
    REQ0 = 1'b0; REQ1 = 1'b0;
    CMD0 = 8'h00; CMD1 = 8'h00; ARG0 = 8'h00; ARG1 = 8'h00;
    HAS_ARG0 = 1'b0; HAS_ARG1 = 1'b0;
    clear_model();
    repeat (3) @(negedge CLK);
    check("reset_outputs", outs(), 32'd0);
    RESET = 1'b0;

    // Port 1, single byte F4, immediate ACK, with latency checks.
    set_port(1, 8'hF4, 8'h00, 0);
    plan_txn(1, 8'hF4, 8'h00, 0, 0);
    @(negedge CLK); REQ1 = 1'b1;
    @(negedge CLK); check("req_to_gnt", {29'b0, GNT1, BUSY, SEND_BYTE}, 32'd6);
    @(negedge CLK); check("gnt_to_send", {23'b0, SEND_BYTE, BYTE_TO_SEND}, {23'b0, 1'b1, 8'hF4});
    wait_done(1); REQ1 = 1'b0;

    // Port 0, F3 with argument 28, ACK each.
    set_port(0, 8'hF3, 8'h28, 1);
    plan_txn(0, 8'hF3, 8'h28, 1, 0);
    @(negedge CLK); REQ0 = 1'b1;
    wait_done(0); REQ0 = 1'b0;

    // E8/03: argument answered FE twice, then FA.
    set_port(0, 8'hE8, 8'h03, 1);
    script_q.push_back(mk(0, 2'b00, ACK));
    script_q.push_back(mk(0, 2'b00, NAK));
    script_q.push_back(mk(0, 2'b00, NAK));
    script_q.push_back(mk(0, 2'b00, ACK));
    plan_txn(0, 8'hE8, 8'h03, 1, 0);
    @(negedge CLK); REQ0 = 1'b1;
    wait_done(0); REQ0 = 1'b0;

    // FF with a silent device: four transmissions separated by timeouts, then ERR.
    set_port(1, 8'hFF, 8'h00, 0);
    for (int i = 0; i < 4; i++) script_q.push_back(mk(1, 2'b00, 8'h00));
    plan_txn(1, 8'hFF, 8'h00, 0, 0);
    send_cyc_q.delete();
    @(negedge CLK); REQ1 = 1'b1;
    wait_done(1); REQ1 = 1'b0;
    check("timeout_tx_count", send_cyc_q.size(), 32'd4);
    for (int i = 1; i < send_cyc_q.size(); i++)
      check("timeout_gap", {31'b0, (send_cyc_q[i] - send_cyc_q[i-1]) >= int'(TO)}, 32'd1);

    // Both requests in the same cycle; the first winner drops its request after DONE.
    set_port(0, 8'hE6, 8'h00, 0);
    set_port(1, 8'hE7, 8'h00, 0);
    w = winner();
    plan_txn(w, w ? 8'hE7 : 8'hE6, 8'h00, 0, 0);
    plan_txn(!w, w ? 8'hE6 : 8'hE7, 8'h00, 0, 0);
    @(negedge CLK); REQ0 = 1'b1; REQ1 = 1'b1;
    wait_done(w); set_req(w, 0);
    wait_done(!w); set_req(!w, 0);

    // Both requests held through four grants.
    set_port(0, 8'hF0, 8'h11, 1);
    set_port(1, 8'hF1, 8'h22, 0);
    for (int k = 0; k < 4; k++) begin
      w = winner();
      plan_txn(w, w ? 8'hF1 : 8'hF0, w ? 8'h22 : 8'h11, !w, 0);
      if (k == 0) begin
        @(negedge CLK); REQ0 = 1'b1; REQ1 = 1'b1;
      end
      wait_done(w);
    end
    REQ0 = 1'b0; REQ1 = 1'b0;

    // Reset asserted in the command ACK wait: outputs clear at once and no DONE follows.
    set_port(0, 8'hF2, 8'h00, 0);
    dev_q.push_back(mk(1, 2'b00, 8'h00));
    @(negedge CLK); REQ0 = 1'b1;
    seen = 0;
    for (int n = 0; n < 200 && seen == 0; n++) begin
      @(negedge CLK);
      if (READ_ENABLE) seen = 1;
    end
    check("reached_ack_wait", seen, 32'd1);
    #2 RESET = 1'b1;
    #1 check("async_reset_outputs", outs(), 32'd0);
    REQ0 = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    clear_model();
    RESET = 1'b0;
    repeat (5) @(negedge CLK);
    set_port(1, 8'hF5, 8'h00, 0);
    plan_txn(1, 8'hF5, 8'h00, 0, 0);
    @(negedge CLK); REQ1 = 1'b1;
    wait_done(1); REQ1 = 1'b0;

    // Randomized transactions against the reference model.
    for (int t = 0; t < 30; t++) begin
      p = 1'($urandom_range(0, 1));
      c = 8'($urandom);
      a = 8'($urandom);
      h = 1'($urandom_range(0, 1));
      set_port(p, c, a, h);
      plan_txn(p, c, a, h, 1);
      @(negedge CLK); set_req(p, 1);
      wait_done(p); set_req(p, 0);
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end

    repeat (5) @(negedge CLK);
    check("queues_drained", exp_port_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mouse_cmd_arbiter.md
Name: mouse_cmd_arbiter

Overview:
- Shares the single PS/2 mouse transmitter/receiver pair between two command requesters: port 0 is the mouse init/stream state machine, port 1 is the processor bus config path (sample rate, resolution, reset commands).
- Sequences each command: send the command byte, await ACK, optionally send one argument byte, await ACK.
- Retries on resend, receiver error or timeout, then reports done or error to the requester that owns the grant.
- Sits between the requesters and the transmitter/receiver handshake ports inside the mouse transceiver.

Parameters:
- TIMEOUT_CYCLES, 2000000, CLK cycles allowed in any wait state before a timeout is declared (20 ms at 100 MHz); counter width is clog2(TIMEOUT_CYCLES+1).
- MAX_RETRIES, 3, resend attempts allowed per byte before the transaction fails.
- ACK_BYTE, 8'hFA, device acknowledge code.
- RESEND_BYTE, 8'hFE, device resend request code.

Ports:
- CLK  in  1  system clock
- RESET  in  1  asynchronous, active-high reset
- REQ0/REQ1  in  1  level request; must be held until the matching DONE
- CMD0/CMD1  in  8  command byte
- ARG0/ARG1  in  8  argument byte
- HAS_ARG0/HAS_ARG1  in  1  command carries one argument byte
- GNT0/GNT1  out  1  high for the whole owned transaction
- DONE0/DONE1  out  1  one-cycle completion pulse
- ERR0/ERR1  out  1  one-cycle failure pulse, coincident with DONE
- SEND_BYTE  out  1  one-cycle pulse to the transmitter
- BYTE_TO_SEND  out  8  byte presented to the transmitter; stable from the SEND_BYTE pulse until BYTE_SENT
- BYTE_SENT  in  1  transmitter completion pulse
- READ_ENABLE  out  1  receiver enable
- BYTE_READY  in  1  receiver byte-valid pulse
- BYTE_READ  in  8  received byte
- BYTE_ERROR_CODE  in  2  receiver error; 00 means OK
- BUSY  out  1  transaction in progress; stream packet consumer pauses while high
- LAST_RESP  out  8  last byte received during any ACK wait

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; every output 0, including BYTE_TO_SEND and LAST_RESP; retry and timeout counters cleared. Reset mid-transaction drops SEND_BYTE and GNT at once and sends no DONE.
- IDLE: with any REQ high, arbitrate and latch that port's CMD, ARG and HAS_ARG; the grant goes to that port. Next cycle GNTx=1, BUSY=1, state=SEND_CMD. Default arbitration is fixed priority, port 0 wins ties.
- SEND_CMD: SEND_BYTE=1 for one cycle with BYTE_TO_SEND=latched CMD -> WAIT_CMD_SENT.
- WAIT_CMD_SENT: on BYTE_SENT -> WAIT_CMD_ACK.
- WAIT_CMD_ACK: READ_ENABLE=1. On BYTE_READY, LAST_RESP<=BYTE_READ, then:
  - BYTE_READ==ACK_BYTE and BYTE_ERROR_CODE==00: go to SEND_ARG if HAS_ARG, else DONE.
  - Any other byte or a nonzero error code: retry.
- SEND_ARG / WAIT_ARG_SENT / WAIT_ARG_ACK: same as the command states, using the latched ARG.
- Retry:
  - If retry count < MAX_RETRIES: count++ and return to the SEND state of the current byte only (command or argument), not the whole command.
  - Otherwise -> FAIL.
  - The retry count resets to 0 when a byte is acknowledged.
- Timeout: the counter clears on entry to each WAIT state. Reaching TIMEOUT_CYCLES takes the retry path.
- DONE: DONEx=1 for one cycle; GNTx and BUSY drop the following cycle; -> IDLE.
- FAIL: DONEx=1 and ERRx=1 for the same cycle; GNTx and BUSY drop the following cycle; -> IDLE.
- Minimum gap between grants is one IDLE cycle. A REQ still high in IDLE re-arbitrates and starts a new transaction.
- A REQ dropped mid-transaction is ignored; the transaction completes and its DONE is still pulsed.
- BYTE_READY outside the ACK wait states is ignored. BYTE_SENT outside the SENT wait states is ignored.
- Latency, single-byte command with immediate ACK: REQ->GNT 1 cycle, GNT->SEND_BYTE 1 cycle, ACK->DONE 1 cycle.

Optional Feature:
- Macro MOUSE_ARB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration. A last-grant flag, reset to 1, gives priority to the port not served last. With both REQs continuously high, grants alternate 0,1,0,1.
- Undefined: fixed priority, port 0 always wins; the last-grant flag is not implemented.

Test Plan:
- REQ1, CMD1=F4, HAS_ARG1=0; model sends FA -> one SEND_BYTE with F4, DONE1 pulse, ERR1=0, LAST_RESP=FA, GNT1 and BUSY fall.
- REQ0, CMD0=F3, ARG0=0x28, HAS_ARG0=1; FA after each byte -> SEND_BYTE pulses with F3 then 28, then DONE0.
- CMD=E8, ARG=03; command ACK FA, argument answered FE twice then FA -> bytes sent E8,03,03,03; DONE without ERR.
- CMD=FF, model never responds -> 4 transmissions of FF, each TIMEOUT_CYCLES apart, then DONE and ERR pulse together.
- REQ0 and REQ1 rise in the same cycle, both held -> fixed priority: port 0 served first, port 1 after the IDLE gap; with MOUSE_ARB_ROUND_ROBIN_EN: 0,1,0,1.
- RESET asserted during WAIT_CMD_ACK -> all outputs 0 asynchronously, no DONE; a fresh request afterwards completes normally.
